// File: rtl/synapse_event_scheduler_pkg.sv
// rtl/synapse_event_scheduler_pkg.sv - shared state encoding and width helpers for the event scheduler
package synapse_event_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int ptr_width(input int channels);
    return clog2_min1(channels);
  endfunction

  // Counter must be able to hold p_gap itself.
  function automatic int gap_width(input int gap);
    return clog2_min1(gap + 1);
  endfunction

endpackage

// File: rtl/synapse_event_scheduler_rr_arbiter.sv
// rtl/synapse_event_scheduler_rr_arbiter.sv - combinational round-robin arbiter, first request at or after the pointer
module rr_arbiter #(
  parameter int p_n     = 8,
  parameter int p_ptr_w = 3
) (
  input  logic [p_n-1:0]     i_req,
  input  logic [p_ptr_w-1:0] i_ptr,
  output logic [p_n-1:0]     o_grant,
  output logic [p_ptr_w-1:0] o_grant_idx,
  output logic               o_valid
);

  int j;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_valid     = 1'b0;
    j           = 0;
    for (int k = 0; k < p_n; k++) begin
      j = (int'(i_ptr) + k) % p_n;
      if (!o_valid && i_req[j]) begin
        o_valid     = 1'b1;
        o_grant_idx = p_ptr_w'(j);
        o_grant[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/synapse_event_scheduler.sv
// rtl/synapse_event_scheduler.sv - per-channel spike capture, round-robin one-hot issue with gap spacing, drop counting
module synapse_event_scheduler
  import synapse_event_scheduler_pkg::*;
#(
  parameter int p_channels  = 8,
  parameter int p_gap       = 2,
  parameter int p_cnt_width = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [p_channels-1:0]  i_event,
  input  logic                   i_drop_clr,
  output logic [p_channels-1:0]  o_event,
  output logic [p_channels-1:0]  o_pending,
  output logic                   o_busy,
  output logic [p_cnt_width-1:0] o_drop_cnt
);

  localparam int PW = ptr_width(p_channels);
  localparam int GW = gap_width(p_gap);
  localparam int SW = p_cnt_width + clog2_min1(p_channels + 1);
  localparam logic [SW-1:0] CNT_MAX = (SW'(1) << p_cnt_width) - SW'(1);

  state_t                 state_q, state_d;
  logic [p_channels-1:0]  pending_q, pending_d;
  logic [p_channels-1:0]  event_q, event_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [p_cnt_width-1:0] drop_cnt_q, drop_cnt_d;

  logic [p_channels-1:0]  grant_oh;
  logic [PW-1:0]          grant_idx;
  logic                   grant_vld;
  logic                   grant_go;
  logic [p_channels-1:0]  clear;
  logic [p_channels-1:0]  drops;
  logic [SW-1:0]          drop_sum;

  rr_arbiter #(
    .p_n     (p_channels),
    .p_ptr_w (PW)
  ) u_arb (
    .i_req       (pending_q),
    .i_ptr       (ptr_q),
    .o_grant     (grant_oh),
    .o_grant_idx (grant_idx),
    .o_valid     (grant_vld)
  );

  // The pointer advances at grant time, so back-to-back grants in ISSUE already see grant+1.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gap_d    = gap_q;
    event_d  = '0;
    grant_go = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && grant_vld) begin
          grant_go = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (p_gap > 0) begin
          gap_d   = GW'(p_gap);
          state_d = ST_HOLD;
        end else if (i_enable && grant_vld) begin
          grant_go = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant_go) begin
      event_d = grant_oh;
      ptr_d   = (grant_idx == PW'(p_channels - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // A new event on a channel being granted this cycle re-arms it rather than dropping.
  always_comb begin
    clear     = grant_go ? grant_oh : '0;
    drops     = i_event & pending_q & ~clear;
    pending_d = (pending_q & ~clear) | i_event;
    drop_sum  = i_drop_clr ? '0 : SW'(drop_cnt_q);
    for (int i = 0; i < p_channels; i++) begin
      drop_sum = drop_sum + SW'(drops[i]);
    end
    drop_cnt_d = (drop_sum > CNT_MAX) ? '1 : drop_sum[p_cnt_width-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      event_q    <= '0;
      ptr_q      <= '0;
      gap_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      event_q    <= event_d;
      ptr_q      <= ptr_d;
      gap_q      <= gap_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_event    = event_q;
  assign o_pending  = pending_q;
  assign o_drop_cnt = drop_cnt_q;
  assign o_busy     = (state_q != ST_IDLE) || (|pending_q);

endmodule

// File: tb/tb_synapse_event_scheduler.sv
// tb/tb_synapse_event_scheduler.sv - directed-vector bench for the synapse event scheduler
module tb_synapse_event_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       en_a = 1'b0, clr_a = 1'b0;
  logic [7:0] ev_a = '0;
  logic [7:0] oev_a, opend_a, odrop_a;
  logic       obusy_a;

  logic       en_b = 1'b0, clr_b = 1'b0;
  logic [7:0] ev_b = '0;
  logic [7:0] oev_b, opend_b;
  logic [1:0] odrop_b;
  logic       obusy_b;

  logic       en_c = 1'b0, clr_c = 1'b0;
  logic [7:0] ev_c = '0;
  logic [7:0] oev_c, opend_c, odrop_c;
  logic       obusy_c;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] ev_tr [64];
  logic [7:0] pend_tr [64];
  logic       busy_tr [64];
  logic       oh_bad;

  always #5 clk = ~clk;

  synapse_event_scheduler #(.p_channels(8), .p_gap(2), .p_cnt_width(8)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en_a), .i_event(ev_a), .i_drop_clr(clr_a),
    .o_event(oev_a), .o_pending(opend_a), .o_busy(obusy_a), .o_drop_cnt(odrop_a));

  synapse_event_scheduler #(.p_channels(8), .p_gap(2), .p_cnt_width(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en_b), .i_event(ev_b), .i_drop_clr(clr_b),
    .o_event(oev_b), .o_pending(opend_b), .o_busy(obusy_b), .o_drop_cnt(odrop_b));

  synapse_event_scheduler #(.p_channels(8), .p_gap(0), .p_cnt_width(8)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en_c), .i_event(ev_c), .i_drop_clr(clr_c),
    .o_event(oev_c), .o_pending(opend_c), .o_busy(obusy_c), .o_drop_cnt(odrop_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en_a = 0; ev_a = '0; clr_a = 0;
    en_b = 0; ev_b = '0; clr_b = 0;
    en_c = 0; ev_c = '0; clr_c = 0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Cycle 0 of the trace is the cycle ev0 is driven; ev1 goes in cycle 1.
  task automatic run_a(input logic [7:0] ev0, input logic [7:0] ev1, input int n);
    oh_bad = 1'b0;
    for (int k = 0; k < n; k++) begin
      ev_a = (k == 0) ? ev0 : (k == 1) ? ev1 : 8'h00;
      ev_tr[k]   = oev_a;
      pend_tr[k] = opend_a;
      busy_tr[k] = obusy_a;
      if (!$onehot0(oev_a)) oh_bad = 1'b1;
      if (k < n - 1) tick();
    end
    ev_a = 8'h00;
  endtask

  function automatic int count_pulses(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (ev_tr[k] != 8'h00) c++;
    return c;
  endfunction

  initial begin
    logic [7:0] exp_c [5];
    exp_c[0] = 8'h01; exp_c[1] = 8'h02; exp_c[2] = 8'h04; exp_c[3] = 8'h08; exp_c[4] = 8'h00;

    tick();
    tick();
    check("rst_event", oev_a, 8'h00);
    check("rst_pending", opend_a, 8'h00);
    check("rst_busy", obusy_a, 1'b0);
    check("rst_drop", odrop_a, 8'h00);
    rst_n = 1'b1;

    // single event, latency 2, busy clears after the gap
    do_reset();
    en_a = 1;
    run_a(8'h04, 8'h00, 8);
    check("single_pend_c1", pend_tr[1], 8'h04);
    check("single_evt_c1", ev_tr[1], 8'h00);
    check("single_evt_c2", ev_tr[2], 8'h04);
    check("single_pend_c2", pend_tr[2], 8'h00);
    check("single_evt_c3", ev_tr[3], 8'h00);
    check("single_busy_c4", busy_tr[4], 1'b1);
    check("single_busy_c5", busy_tr[5], 1'b0);
    check("single_count", count_pulses(8), 1);

    // round-robin fairness with all channels pending
    do_reset();
    en_a = 1;
    run_a(8'hFF, 8'h00, 36);
    for (int k = 0; k < 8; k++)
      check($sformatf("rr_ch%0d", k), ev_tr[2 + 4 * k], 8'h01 << k);
    check("rr_count", count_pulses(36), 8);
    check("rr_onehot", oh_bad, 1'b0);
    check("rr_drop", odrop_a, 8'h00);

    // overrun while disabled, then a single issue
    do_reset();
    en_a = 0;
    run_a(8'h01, 8'h01, 3);
    check("ovr_pend", pend_tr[2], 8'h01);
    check("ovr_drop", odrop_a, 8'h01);
    check("ovr_no_pulse", count_pulses(3), 0);
    en_a = 1;
    run_a(8'h00, 8'h00, 8);
    check("ovr_evt_c1", ev_tr[1], 8'h01);
    check("ovr_count", count_pulses(8), 1);
    check("ovr_pend_after", opend_a, 8'h00);
    clr_a = 1;
    tick();
    clr_a = 0;
    check("ovr_clr", odrop_a, 8'h00);

    // new event on the channel being granted re-arms it
    do_reset();
    en_a = 1;
    run_a(8'h08, 8'h08, 8);
    check("regrant_pend_c2", pend_tr[2], 8'h08);
    check("regrant_evt_c2", ev_tr[2], 8'h08);
    check("regrant_evt_c6", ev_tr[6], 8'h08);
    check("regrant_count", count_pulses(8), 2);
    check("regrant_drop", odrop_a, 8'h00);

    // asynchronous reset in HOLD
    do_reset();
    en_a = 1;
    run_a(8'h03, 8'h02, 4);
    check("hold_evt_c2", ev_tr[2], 8'h01);
    check("hold_busy", busy_tr[3], 1'b1);
    check("hold_pend", pend_tr[3], 8'h02);
    check("hold_drop", odrop_a, 8'h01);
    #3 rst_n = 1'b0;
    #1;
    check("arst_event", oev_a, 8'h00);
    check("arst_pending", opend_a, 8'h00);
    check("arst_busy", obusy_a, 1'b0);
    check("arst_drop", odrop_a, 8'h00);
    #2 rst_n = 1'b1;
    tick();

    // saturating 2-bit drop counter and clear interactions
    do_reset();
    ev_b = 8'hFF;
    tick();
    ev_b = 8'h1F;
    tick();
    check("sat_five", odrop_b, 2'd3);
    ev_b = 8'h01; clr_b = 1;
    tick();
    check("clr_with_drop", odrop_b, 2'd1);
    ev_b = 8'h00; clr_b = 1;
    tick();
    check("clr_alone", odrop_b, 2'd0);
    ev_b = 8'h03; clr_b = 0;
    tick();
    check("sat_two", odrop_b, 2'd2);
    ev_b = 8'h03;
    tick();
    check("sat_four", odrop_b, 2'd3);
    ev_b = 8'h00;

    // zero gap: backlog drains one pulse per cycle
    do_reset();
    ev_c = 8'h0F;
    tick();
    ev_c = 8'h00;
    check("gap0_pend", opend_c, 8'h0F);
    en_c = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("gap0_c%0d", k), oev_c, exp_c[k]);
    end
    check("gap0_drop", odrop_c, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
